// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - display bus and decoded frame signals
// master drives the display pins and observes frames; slave is the decoder.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an_in;
  logic [6:0]              seg_in;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;
  logic                    frame_err;
  logic                    link_lost;

  modport master (
    output an_in, seg_in,
    input  bcd_out, digit_err, frame_valid, frame_err, link_lost
  );

  modport slave (
    input  an_in, seg_in,
    output bcd_out, digit_err, frame_valid, frame_err, link_lost
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers BCD frames from a scanned 7-segment bus
// Debounces each anode/segment dwell, decodes it, and publishes full frames.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_decoder_if.slave bus
);
  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);
  localparam logic [16:0]   TIMEOUT = 17'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {ACQUIRE, PUBLISH} state_t;

  state_t                  state_q;
  logic [W-1:0]            sync1_q, sync2_q, prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [16:0]             idle_q, idle_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
  logic [NUM_DIGITS-1:0]   errbuf_q, errbuf_d;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   derr_q;
  logic                    ferr_q, lost_q;

  logic                    same, accept, take, publish, timeout;
  logic [NUM_DIGITS-1:0]   an_low;
  logic [4:0]              dec;

  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  always_comb begin
    same   = (sync2_q == prev_q);
    cnt_d  = same ? ((cnt_q == STABLE) ? cnt_q : cnt_q + CW'(1)) : CW'(1);
    // A dwell fires once when its count first reaches STABLE; done_q blocks repeats.
    accept = (cnt_d == STABLE) && !(same && done_q);
    done_d = accept | (same & done_q);
    an_low = ~sync2_q[W-1:7];
    take   = accept && $onehot(an_low);
    dec    = decode(sync2_q[6:0]);

    seen_d   = seen_q;
    buf_d    = buf_q;
    errbuf_d = errbuf_q;
    if (take) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (an_low[k]) begin
          seen_d[k]       = 1'b1;
          buf_d[4*k +: 4] = dec[3:0];
          errbuf_d[k]     = dec[4];
        end
      end
    end
    publish = &seen_d;

    idle_d  = take ? 17'd0 : ((idle_q == TIMEOUT) ? idle_q : idle_q + 17'd1);
    timeout = !take && (idle_d == TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACQUIRE;
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      idle_q   <= '0;
      seen_q   <= '0;
      buf_q    <= '1;
      errbuf_q <= '0;
      bcd_q    <= '1;
      derr_q   <= '0;
      ferr_q   <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      sync1_q  <= {bus.an_in, bus.seg_in};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
      buf_q    <= buf_d;
      errbuf_q <= errbuf_d;
      if (publish) begin
        // Outputs load on the completing edge so they are valid in the PUBLISH cycle.
        state_q <= PUBLISH;
        bcd_q   <= buf_d;
        derr_q  <= errbuf_d;
        ferr_q  <= |errbuf_d;
        lost_q  <= 1'b0;
        seen_q  <= '0;
      end else begin
        state_q <= ACQUIRE;
        seen_q  <= timeout ? '0 : seen_d;
        if (timeout) lost_q <= 1'b1;
      end
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.digit_err   = derr_q;
  assign bus.frame_valid = (state_q == PUBLISH);
  assign bus.frame_err   = ferr_q;
  assign bus.link_lost   = lost_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
// Dwell-level reference model of the display bus against observed frames.
module tb_seg7_scan_decoder;
  localparam int N = 4;
  localparam int S = 4;
  localparam int T = 100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS(N), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0]  seg_tab [0:9];
  logic [3:0]  m_buf [N];
  logic [N-1:0] m_err, m_seen;
  logic [10:0] m_word;
  int          m_run;
  logic [20:0] exp_q [$];
  logic [20:0] obs_q [$];

  always @(negedge clk)
    if (rst_n === 1'b1 && bus.frame_valid === 1'b1)
      obs_q.push_back({bus.bcd_out, bus.digit_err, bus.frame_err});

  function automatic logic [4:0] ref_decode(input logic [6:0] seg);
    for (int i = 0; i < 10; i++)
      if (seg == seg_tab[i]) return {1'b0, 4'(i)};
    if (seg == 7'h7F) return 5'h0F;
    return 5'h1E;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_buf[i] = 4'hF;
    m_err  = '0;
    m_seen = '0;
    m_word = '1;
    m_run  = 0;
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int dur);
    logic [10:0] w;
    logic [15:0] b;
    logic [4:0]  d;
    int prior, k;
    bit acc;
    w = {an, seg};
    if (w == m_word) begin
      prior = m_run;
      m_run += dur;
      acc = (prior < S) && (m_run >= S);
    end else begin
      m_word = w;
      m_run  = dur;
      acc = (dur >= S);
    end
    if (acc && $countones(~an) == 1) begin
      k = 0;
      for (int i = 0; i < N; i++) if (!an[i]) k = i;
      d = ref_decode(seg);
      m_buf[k]  = d[3:0];
      m_err[k]  = d[4];
      m_seen[k] = 1'b1;
      if (&m_seen) begin
        for (int i = 0; i < N; i++) b[4*i +: 4] = m_buf[i];
        exp_q.push_back({b, m_err, |m_err});
        m_seen = '0;
      end
    end
    bus.an_in  = an;
    bus.seg_in = seg;
    repeat (dur) @(posedge clk);
    #1;
  endtask

  task automatic show(input int k, input logic [6:0] seg, input int dur);
    logic [3:0] an;
    an = ~(4'b0001 << k);
    dwell(an, seg, dur);
  endtask

  task automatic flush();
    dwell(4'hF, 7'h7F, 12);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.an_in  = 4'hF;
    bus.seg_in = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.an_in  = 4'hF;
    bus.seg_in = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.bcd_out !== 16'hFFFF) begin n_bad++; $display("FAIL reset_bcd: got %h want ffff", bus.bcd_out); end
    n_cmp++; if (bus.digit_err !== 4'h0) begin n_bad++; $display("FAIL reset_derr: got %b want 0000", bus.digit_err); end
    n_cmp++; if (bus.frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %b want 0", bus.frame_valid); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
    n_cmp++; if (bus.link_lost !== 1'b1) begin n_bad++; $display("FAIL reset_lost: got %b want 1", bus.link_lost); end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_scan_basic();
    show(0, seg_tab[1], 8); show(1, seg_tab[2], 8);
    show(2, seg_tab[3], 8); show(3, seg_tab[4], 8);
    flush();
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++; if (obs_q[0] !== {16'h4321, 4'b0000, 1'b0}) begin n_bad++; $display("FAIL basic_frame: got %h want %h", obs_q[0], {16'h4321, 4'b0000, 1'b0}); end
    end
    n_cmp++; if (bus.link_lost !== 1'b0) begin n_bad++; $display("FAIL basic_lost: got %b want 0", bus.link_lost); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_illegal();
    show(0, seg_tab[5], 8); show(1, seg_tab[6], 8);
    show(2, 7'b1111110, 8); show(3, seg_tab[8], 8);
    flush();
    n_cmp++; if (bus.bcd_out !== 16'h8E65) begin n_bad++; $display("FAIL illegal_bcd: got %h want 8e65", bus.bcd_out); end
    n_cmp++; if (bus.digit_err !== 4'b0100) begin n_bad++; $display("FAIL illegal_derr: got %b want 0100", bus.digit_err); end
    n_cmp++; if (bus.frame_err !== 1'b1) begin n_bad++; $display("FAIL illegal_ferr: got %b want 1", bus.frame_err); end
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL illegal_count: got %0d want 1", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    show(0, seg_tab[9], 8); show(0, seg_tab[8], 3); show(0, seg_tab[9], 8);
    show(1, seg_tab[0], 8); show(2, seg_tab[7], 8); show(3, seg_tab[3], 8);
    flush();
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL glitch_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++; if (obs_q[0] !== {16'h3709, 4'b0000, 1'b0}) begin n_bad++; $display("FAIL glitch_frame: got %h want %h", obs_q[0], {16'h3709, 4'b0000, 1'b0}); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad_anodes();
    show(0, seg_tab[2], 8); show(1, seg_tab[5], 8);
    dwell(4'b1100, seg_tab[4], 20);
    dwell(4'b1111, seg_tab[6], 20);
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL badan_early: got %0d frames want 0", obs_q.size()); end
    show(2, seg_tab[7], 8); show(3, seg_tab[1], 8);
    flush();
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL badan_count: got %0d want 1", obs_q.size()); end
    n_cmp++; if (bus.bcd_out !== 16'h1752) begin n_bad++; $display("FAIL badan_bcd: got %h want 1752", bus.bcd_out); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [3:0] an;
    logic [6:0] seg;
    int r;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 90) an = ~(4'b0001 << $urandom_range(0, N - 1));
      else        an = 4'($urandom);
      r = $urandom_range(0, 99);
      if (r < 60)      seg = seg_tab[$urandom_range(0, 9)];
      else if (r < 75) seg = 7'h7F;
      else             seg = 7'($urandom);
      dwell(an, seg, $urandom_range(1, 10));
    end
    flush();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_frame[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    show(0, seg_tab[5], 8); show(1, seg_tab[6], 8);
    show(2, seg_tab[7], 8); show(3, seg_tab[8], 8);
    show(0, seg_tab[3], 8); show(1, seg_tab[3], 8);
    dwell(4'hF, 7'h7F, 90);
    n_cmp++; if (bus.link_lost !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b want 0", bus.link_lost); end
    dwell(4'hF, 7'h7F, 20);
    m_seen = '0;
    n_cmp++; if (bus.link_lost !== 1'b1) begin n_bad++; $display("FAIL tmo_lost: got %b want 1", bus.link_lost); end
    n_cmp++; if (bus.bcd_out !== 16'h8765) begin n_bad++; $display("FAIL tmo_held: got %h want 8765", bus.bcd_out); end
    show(2, seg_tab[4], 8); show(3, seg_tab[9], 8);
    flush();
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL tmo_partial: got %0d frames want 1", obs_q.size()); end
    n_cmp++; if (bus.link_lost !== 1'b1) begin n_bad++; $display("FAIL tmo_still_lost: got %b want 1", bus.link_lost); end
    show(0, seg_tab[1], 8); show(1, seg_tab[2], 8);
    flush();
    n_cmp++; if (bus.bcd_out !== 16'h9421) begin n_bad++; $display("FAIL tmo_recover_bcd: got %h want 9421", bus.bcd_out); end
    n_cmp++; if (bus.link_lost !== 1'b0) begin n_bad++; $display("FAIL tmo_recover_lost: got %b want 0", bus.link_lost); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midframe();
    show(0, seg_tab[7], 8); show(1, seg_tab[7], 8);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.bcd_out !== 16'hFFFF) begin n_bad++; $display("FAIL mid_bcd: got %h want ffff", bus.bcd_out); end
    n_cmp++; if (bus.link_lost !== 1'b1) begin n_bad++; $display("FAIL mid_lost: got %b want 1", bus.link_lost); end
    n_cmp++; if (bus.frame_valid !== 1'b0) begin n_bad++; $display("FAIL mid_fv: got %b want 0", bus.frame_valid); end
    apply_reset();
    show(2, seg_tab[5], 8); show(3, seg_tab[6], 8);
    flush();
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL mid_partial: got %0d frames want 0", obs_q.size()); end
    show(0, seg_tab[1], 8); show(1, seg_tab[2], 8);
    flush();
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL mid_count: got %0d want 1", obs_q.size()); end
    n_cmp++; if (bus.bcd_out !== 16'h6521) begin n_bad++; $display("FAIL mid_bcd_after: got %h want 6521", bus.bcd_out); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    test_reset();
    test_scan_basic();
    test_illegal();
    test_glitch();
    test_bad_anodes();
    test_random();
    test_timeout();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
